// File: rtl/alu_addsub_if.sv
// Operand, control and result bundle between the datapath and alu_addsub.
// master drives operands/control; slave is the ALU side.
interface alu_addsub_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       op;
    logic             start;
    logic             eu;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_out;
    logic [WIDTH-1:0] bus_out;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output a_in, b_in, op, start, eu,
        input  busy, done, result_out, bus_out,
        input  flag_c, flag_z, flag_n, flag_v
    );

    modport slave (
        input  a_in, b_in, op, start, eu,
        output busy, done, result_out, bus_out,
        output flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_addsub.sv
// 8-bit datapath ALU: ADD/SUB/PASS_B with flags, bus output under eu.
// Define ALU_MUL_EN to make op 11 an unsigned shift-add multiply.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    alu_addsub_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd3;
`ifdef ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam int         CNT_W  = $clog2(WIDTH + 1);
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_PAS = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic             z_q;
    logic             n_q;
    logic             v_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c_nx;
    logic             v_nx;

    // SUB is A + ~B + 1, so carry out doubles as "no borrow"
    always_comb begin
        sum  = '0;
        r    = '0;
        c_nx = 1'b0;
        v_nx = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum  = {1'b0, a_q} + {1'b0, b_q};
                r    = sum[WIDTH-1:0];
                c_nx = sum[WIDTH];
                v_nx = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum  = {1'b0, a_q} + {1'b0, ~b_q} +
                       (WIDTH+1)'(1);
                r    = sum[WIDTH-1:0];
                c_nx = sum[WIDTH];
                v_nx = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                       (r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_PAS: begin
                r = b_q;
            end
            default: begin
                r = '0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod_nx;

    assign prod_nx = mplr[0] ? prod + mcand : prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            v_q   <= 1'b0;
`ifdef ALU_MUL_EN
            prod  <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.start) begin
                        a_q   <= io.a_in;
                        b_q   <= io.b_in;
                        op_q  <= io.op;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q != OP_MUL) begin
                        res_q <= r;
                        c_q   <= c_nx;
                        z_q   <= (r == '0);
                        n_q   <= r[WIDTH-1];
                        v_q   <= v_nx;
                        state <= S_DONE;
                    end else begin
`ifdef ALU_MUL_EN
                        prod  <= '0;
                        mcand <= {{WIDTH{1'b0}}, a_q};
                        mplr  <= b_q;
                        cnt   <= '0;
                        state <= S_MUL;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod  <= prod_nx;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        res_q <= prod_nx[WIDTH-1:0];
                        c_q   <= |prod_nx[2*WIDTH-1:WIDTH];
                        z_q   <= (prod_nx[WIDTH-1:0] == '0);
                        n_q   <= prod_nx[WIDTH-1];
                        v_q   <= 1'b0;
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.busy       = (state != S_IDLE);
    assign io.done       = (state == S_DONE);
    assign io.result_out = res_q;
    assign io.bus_out    = io.eu ? res_q : '0;
    assign io.flag_c     = c_q;
    assign io.flag_z     = z_q;
    assign io.flag_n     = n_q;
    assign io.flag_v     = v_q;
endmodule

// File: tb/tb_alu_addsub.sv
// Self-checking bench for alu_addsub: directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_addsub;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] exp_res;
    logic [3:0] exp_f;

    alu_addsub_if #(.WIDTH(8)) io();

    alu_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns the edge index (start = edge t) at which done is seen
    function automatic int model(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [1:0] o
    );
        int s;
        int sr;
        int sa;
        int sb;
        logic c;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'b00: begin
                s = int'(a) + int'(b);
                sr = sa + sb;
                exp_res = s[7:0];
                c = (s > 255);
                v = (sr > 127) || (sr < -128);
            end
            2'b01: begin
                sr = sa - sb;
                exp_res = 8'(int'(a) - int'(b));
                c = (a >= b);
                v = (sr > 127) || (sr < -128);
            end
            2'b10: begin
                exp_res = b;
            end
            default: begin
`ifdef ALU_MUL_EN
                s = int'(a) * int'(b);
                exp_res = s[7:0];
                exp_f = {s > 255, s[7:0] == 0, s[7], 1'b0};
                return 10;
`else
                return 2;
`endif
            end
        endcase
        exp_f = {c, exp_res == 8'h00, exp_res[7], v};
        return 2;
    endfunction

    // mode 1: re-pulse start with new operands while busy
    // mode 2: toggle eu every cycle during the operation
    task automatic do_op(
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  logic [1:0] o,
        input  int         mode,
        output int         lat,
        output int         pulses
    );
        lat = -1;
        pulses = 0;
        @(negedge clk);
        io.a_in = a;
        io.b_in = b;
        io.op = o;
        io.start = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) io.a_in = 8'hFF;
        else io.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mode == 2) io.eu = ~io.eu;
            if (mode == 1 && k == 2) begin
                io.start = 1'b0;
                io.b_in = 8'h77;
                io.op = 2'b01;
            end
            if (io.done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (lat > 0 && k >= lat + 3) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io.eu = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (io.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b want 0", io.busy);
        end
        checks++;
        if (io.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got %b want 0", io.done);
        end
        checks++;
        if (io.result_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_res got %h want 00", io.result_out);
        end
        checks++;
        if ({io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== 4'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 0000",
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v});
        end
        checks++;
        if (io.bus_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_bus got %h want 00", io.bus_out);
        end
        reset = 1'b0;
        exp_res = 8'h00;
        exp_f = 4'b0;
    endtask

    task automatic test_add_overflow();
        int lat;
        int p;
        do_op(8'h7F, 8'h01, 2'b00, 0, lat, p);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL add_lat got %0d want 2", lat);
        end
        checks++;
        if (io.result_out !== 8'h80) begin
            errors++;
            $display("FAIL add_res got %h want 80", io.result_out);
        end
        checks++;
        if ({io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== 4'b0011) begin
            errors++;
            $display("FAIL add_flags got %b want 0011",
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v});
        end
        exp_res = 8'h80;
        exp_f = 4'b0011;
    endtask

    task automatic test_sub();
        int lat;
        int p;
        do_op(8'h05, 8'h05, 2'b01, 0, lat, p);
        checks++;
        if (io.result_out !== 8'h00 || lat !== 2) begin
            errors++;
            $display("FAIL sub_eq got %h lat %0d want 00 lat 2",
                     io.result_out, lat);
        end
        checks++;
        if ({io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== 4'b1100) begin
            errors++;
            $display("FAIL sub_eq_flags got %b want 1100",
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v});
        end
        do_op(8'h03, 8'h05, 2'b01, 0, lat, p);
        checks++;
        if (io.result_out !== 8'hFE) begin
            errors++;
            $display("FAIL sub_brw got %h want fe", io.result_out);
        end
        checks++;
        if ({io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== 4'b0010) begin
            errors++;
            $display("FAIL sub_brw_flags got %b want 0010",
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v});
        end
        exp_res = 8'hFE;
        exp_f = 4'b0010;
    endtask

    task automatic test_capture();
        int lat;
        int p;
        do_op(8'h10, 8'h20, 2'b00, 1, lat, p);
        checks++;
        if (p !== 1 || lat !== 2) begin
            errors++;
            $display("FAIL cap_done got %0d pulses lat %0d want 1 lat 2",
                     p, lat);
        end
        checks++;
        if (io.result_out !== 8'h30) begin
            errors++;
            $display("FAIL cap_res got %h want 30", io.result_out);
        end
        exp_res = 8'h30;
        exp_f = 4'b0000;
    endtask

    task automatic test_bus();
        int lat;
        int p;
        @(negedge clk);
        io.eu = 1'b0;
        #1;
        checks++;
        if (io.bus_out !== 8'h00) begin
            errors++;
            $display("FAIL bus_off got %h want 00", io.bus_out);
        end
        io.eu = 1'b1;
        #1;
        checks++;
        if (io.bus_out !== 8'h30) begin
            errors++;
            $display("FAIL bus_on got %h want 30", io.bus_out);
        end
        do_op(8'h44, 8'h22, 2'b01, 2, lat, p);
        io.eu = 1'b1;
        #1;
        checks++;
        if (lat !== 2 || io.bus_out !== 8'h22) begin
            errors++;
            $display("FAIL bus_tgl got lat %0d bus %h want 2 22",
                     lat, io.bus_out);
        end
        exp_res = 8'h22;
        exp_f = 4'b1000;
    endtask

    task automatic test_reset_midop();
        int p;
        @(negedge clk);
        io.a_in = 8'h09;
        io.b_in = 8'h03;
        io.op = 2'b01;
        io.start = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (io.busy !== 1'b0 || io.done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ctl got busy %b done %b want 0 0",
                     io.busy, io.done);
        end
        checks++;
        if (io.result_out !== 8'h00 ||
            {io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== 4'b0) begin
            errors++;
            $display("FAIL rmid_state got %h/%b want 00/0000", io.result_out,
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v});
        end
        p = 0;
        repeat (6) begin
            @(negedge clk);
            if (io.done) p++;
        end
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL rmid_nodone got %0d pulses want 0", p);
        end
        exp_res = 8'h00;
        exp_f = 4'b0;
    endtask

    task automatic test_mul();
        int lat;
        int p;
        int el;
        el = model(8'h10, 8'h11, 2'b11);
        do_op(8'h10, 8'h11, 2'b11, 0, lat, p);
        checks++;
        if (lat !== el || p !== 1) begin
            errors++;
            $display("FAIL mul_lat got %0d (%0d pulses) want %0d",
                     lat, p, el);
        end
        checks++;
        if (io.result_out !== exp_res) begin
            errors++;
            $display("FAIL mul_res got %h want %h", io.result_out, exp_res);
        end
        checks++;
        if ({io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== exp_f) begin
            errors++;
            $display("FAIL mul_flags got %b want %b",
                     {io.flag_c, io.flag_z, io.flag_n, io.flag_v}, exp_f);
        end
    endtask

    task automatic test_random();
        int lat;
        int p;
        int el;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] o;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            o = 2'($urandom_range(0, 3));
            el = model(a, b, o);
            do_op(a, b, o, 0, lat, p);
            checks++;
            if (lat !== el || p !== 1 || io.result_out !== exp_res ||
                {io.flag_c, io.flag_z, io.flag_n, io.flag_v} !== exp_f) begin
                errors++;
                $display("FAIL rnd%0d op%0d %h,%h got %h/%b lat %0d want %h/%b lat %0d",
                         i, o, a, b, io.result_out,
                         {io.flag_c, io.flag_z, io.flag_n, io.flag_v},
                         lat, exp_res, exp_f, el);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        io.a_in = '0;
        io.b_in = '0;
        io.op = '0;
        io.start = 1'b0;
        io.eu = 1'b1;
        test_reset();
        test_add_overflow();
        test_sub();
        test_capture();
        test_bus();
        test_reset_midop();
        test_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
